// File: rtl/wb_regfile_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile_stage_pkg
// Description : Shared constants and result-select encoding for the WB stage.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_regfile_stage_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int RA_IDX = 31;

    typedef enum logic [1:0] {
        MEMTOREG_ALU  = 2'b00,
        MEMTOREG_MEM  = 2'b01,
        MEMTOREG_HALF = 2'b10,
        MEMTOREG_BYTE = 2'b11
    } memtoreg_e;

endpackage
`default_nettype wire

// File: rtl/wb_regfile_stage_gpr_file.sv
`default_nettype none
// ============================================================================
// Module      : gpr_file
// Description : 2R1W register file, r0 hardwired to zero, write-through reads.
// Revision    : 1.0 - initial release
// ============================================================================
module gpr_file #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [REG_AW-1:0] ra1_i,
    input  logic [REG_AW-1:0] ra2_i,
    output logic [DATA_W-1:0] rd1_o,
    output logic [DATA_W-1:0] rd2_o
);
    import wb_regfile_stage_pkg::*;

    localparam int NREG = 2 ** REG_AW;

    logic [DATA_W-1:0] regs_q [NREG];

    // Entry 0 is cleared by reset and never written, so it always holds zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rd1_o = regs_q[ra1_i];
        if (ra1_i == '0) begin
            rd1_o = '0;
        end else if (we_i && (ra1_i == waddr_i)) begin
            rd1_o = wdata_i;
        end
    end

    always_comb begin
        rd2_o = regs_q[ra2_i];
        if (ra2_i == '0) begin
            rd2_o = '0;
        end else if (we_i && (ra2_i == waddr_i)) begin
            rd2_o = wdata_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_regfile_stage.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile_stage
// Description : Writeback stage: result select, GPR file and HI/LO registers.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile_stage #(
    parameter int DATA_W = wb_regfile_stage_pkg::DATA_W,
    parameter int REG_AW = wb_regfile_stage_pkg::REG_AW,
    parameter int RA_IDX = wb_regfile_stage_pkg::RA_IDX
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              jalW,
    input  logic              regwriteW,
    input  logic [1:0]        memtoregW,
    input  logic [DATA_W-1:0] aluoutW,
    input  logic [DATA_W-1:0] readdataW,
    input  logic [DATA_W-1:0] halfwordW,
    input  logic [DATA_W-1:0] byteW,
    input  logic [DATA_W-1:0] PCplusW,
    input  logic [REG_AW-1:0] WriteRegW,
    input  logic              hiwriteW,
    input  logic              lowriteW,
    input  logic              mfhiW,
    input  logic              mfloW,
    input  logic [DATA_W-1:0] Res_hiW,
    input  logic [DATA_W-1:0] Res_loW,
    input  logic [DATA_W-1:0] hi_loW,
    input  logic              CPRdW,
    input  logic [DATA_W-1:0] CPoutW,
    input  logic [REG_AW-1:0] ra1,
    input  logic [REG_AW-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [DATA_W-1:0] hi_q,
    output logic [DATA_W-1:0] lo_q,
    output logic [DATA_W-1:0] resultW,
    output logic              wr_enW,
    output logic [REG_AW-1:0] wr_addrW
);
    import wb_regfile_stage_pkg::*;

    logic [DATA_W-1:0] hi_d;
    logic [DATA_W-1:0] lo_d;

    always_comb begin
        resultW = aluoutW;
        if (jalW) begin
            resultW = PCplusW;
        end else if (CPRdW) begin
            resultW = CPoutW;
        end else if (mfhiW) begin
            resultW = hi_q;
        end else if (mfloW) begin
            resultW = lo_q;
        end else begin
            case (memtoreg_e'(memtoregW))
                MEMTOREG_ALU:  resultW = aluoutW;
                MEMTOREG_MEM:  resultW = readdataW;
                MEMTOREG_HALF: resultW = halfwordW;
                MEMTOREG_BYTE: resultW = byteW;
                default:       resultW = aluoutW;
            endcase
        end
    end

    assign wr_addrW = jalW ? REG_AW'(RA_IDX) : WriteRegW;
    assign wr_enW   = (regwriteW | jalW) & (wr_addrW != '0);

    // A paired write is a mult/div result; a single write is mthi/mtlo.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (hiwriteW && lowriteW) begin
            hi_d = Res_hiW;
            lo_d = Res_loW;
        end else if (hiwriteW) begin
            hi_d = hi_loW;
        end else if (lowriteW) begin
            lo_d = hi_loW;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    gpr_file #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_gpr_file (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (wr_enW),
        .waddr_i (wr_addrW),
        .wdata_i (resultW),
        .ra1_i   (ra1),
        .ra2_i   (ra2),
        .rd1_o   (rd1),
        .rd2_o   (rd2)
    );

endmodule
`default_nettype wire
